cpu_write_buffer: RTL and testbench
===================================

# cpu_write_buffer

Posted-write buffer between the TG68 CPU bus and the `cpu*` port of `sdram_ctrl`. CPU writes to SDRAM are acknowledged as soon as they enter a small FIFO and are drained to the controller in the background. CPU reads and fetches wait until the FIFO is empty, which preserves program order, and are then passed through. The block removes SDRAM write latency from the CPU's critical path without changing `sdram_ctrl`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `sysclk  in  1`: system clock (114 MHz domain of `sdram_ctrl`).
- `reset_n  in  1`: asynchronous, active-low reset.
- `cpuAddr  in  24 [24:1]`: CPU word address.
- `cpustate  in  2`: 00 fetch, 10 read, 11 write, 01 idle. Held stable while a request is pending.
- `cpuL`, `cpuU`  in  1: lower/upper byte enables, active low.
- `cpuWR  in  16`: write data.
- `cpuRD  out  16`: read data; registered; valid in the `cpu_ack` cycle.
- `cpu_ack  out  1`: one-cycle pulse completing the current CPU request.
- `sd_cpuAddr  out  24`, `sd_cpustate  out  2`, `sd_cpuL  out  1`, `sd_cpuU  out  1`, `sd_cpuWR  out  16`: request to `sdram_ctrl`. All registered.
- `sd_cpuRD  in  16`: controller read data; valid when `sd_cpuena`=1.
- `sd_cpuena  in  1`: controller completion pulse for the current request.
- `wb_empty  out  1`: FIFO empty.
- `wb_full  out  1`: FIFO full.

## Operation
- Reset values:
  - `sd_cpustate`=01; `sd_cpuL`=`sd_cpuU`=1; `sd_cpuAddr`=0; `sd_cpuWR`=0.
  - `cpuRD`=0; `cpu_ack`=0.
  - `wb_empty`=1; `wb_full`=0.
  - FIFO pointers 0; FSM in IDLE.
- FIFO entry: {addr[24:1], L, U, data[15:0]}, 42 bits. Circular buffer with `log2(DEPTH)`-bit rd/wr pointers and a `log2(DEPTH)+1`-bit count. Pointers wrap modulo DEPTH.
- CPU-side write accept:
  - Condition: `cpustate`=11, not full, and no `cpu_ack` issued in the previous cycle.
  - Action: push the entry and pulse `cpu_ack` in the next cycle.
  - The CPU must change or drop its request after `cpu_ack`. The one-cycle post-ack guard prevents double-push of a held request.
- Drain FSM states: IDLE, WR_REQ, RD_REQ, GAP.
  - IDLE → WR_REQ when FIFO not empty. Load the head entry onto the `sd_*` outputs with `sd_cpustate`=11.
  - IDLE → RD_REQ when FIFO empty and `cpustate`∈{00,10}. Load the CPU addr/L/U and `sd_cpustate`=`cpustate`.
  - WR_REQ: hold all `sd_*` outputs until `sd_cpuena`=1. Then pop the head, set `sd_cpustate`=01, and go to GAP.
  - RD_REQ: hold until `sd_cpuena`=1. Then capture `sd_cpuRD` into `cpuRD`, pulse `cpu_ack` next cycle, set `sd_cpustate`=01, and go to GAP.
  - GAP: exactly one cycle with `sd_cpustate`=01, then IDLE. The controller needs a deasserted request between transactions.
- Ordering: reads and fetches never bypass buffered writes. A read arriving with a non-empty FIFO waits until the last write's `sd_cpuena`.
- Simultaneous push (CPU write) and pop (drain completion) in one cycle is legal.
  - Count is unchanged.
  - A push into a full FIFO coinciding with a pop is **not** accepted that cycle. Full is evaluated on the registered count.
- Byte enables pass through unmodified. L=U=1 writes are still forwarded.
- `sd_cpuena` while the FSM is in IDLE or GAP is ignored.

## Timing
- Write accept latency: `cpu_ack` 1 cycle after a `cpustate`=11 request is sampled with the FIFO not full.
- Write stall: while full, `cpu_ack` is withheld. It is issued 1 cycle after the first cycle with count<DEPTH.
- Drain start: `sd_cpustate`=11 appears 1 cycle after the FIFO becomes non-empty, when in IDLE.
- Drain throughput: one write per (controller latency + 2) cycles. The +2 is the GAP cycle plus the IDLE load cycle.
- Read latency:
  - Empty FIFO: 1 (load) + controller latency + 1 (ack).
  - Otherwise: add the full drain time of all entries ahead of it.
- `wb_empty`/`wb_full` are combinational from the registered count and change the cycle after push/pop.
- `reset_n` low mid-operation, asynchronously:
  - All outputs return to their reset values.
  - FIFO contents are discarded, including any in-flight write.
  - Any pending `cpu_ack` is cancelled.
- After `reset_n` rises, the first request is sampled on the next `sysclk` edge.

## Test plan
- Single write, empty FIFO: `cpustate`=11, addr 0x000100, data 0xA5A5, L=U=0 → `cpu_ack` at +1. `sd_cpustate`=11 at +2 with identical addr/data. After `sd_cpuena`, one GAP cycle with 01.
- Burst to full, DEPTH=4: 5 back-to-back writes 0x1111..0x5555 with `sd_cpuena` held off → 4 acks, `wb_full`=1, 5th stalled. A single `sd_cpuena` → 5th acked and FIFO drains in order 0x1111..0x5555.
- Read after write: write 0xBEEF to 0x000200, then immediate read of 0x000200 → `sd_cpustate`=10 issued only after the write's `sd_cpuena`. `cpuRD`=0xBEEF (SDRAM model) in the `cpu_ack` cycle.
- Simultaneous push/pop: count=2, a CPU write accepted in the same cycle as a drain `sd_cpuena` → count stays 2. Pointers wrap correctly across 8 further writes.
- Byte lanes: write L=0, U=1, data 0x12FF to 0x000300 → `sd_cpuL`=0, `sd_cpuU`=1 forwarded. A subsequent read returns the upper byte unchanged.
- Reset mid-drain: 3 entries buffered and `sd_cpustate`=11 → pulse `reset_n` low asynchronously. Outputs go to reset values immediately, `wb_empty`=1, and no further `sd_*` request until a new CPU write.

Source files
------------

// File: rtl/cpu_write_buffer.sv
// cpu_write_buffer: posted-write FIFO between the TG68 bus and sdram_ctrl.
// Writes are acked on entry; reads/fetches wait for an empty FIFO.
module cpu_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic [24:1] cpuAddr,
  input  logic [1:0]  cpustate,
  input  logic        cpuL,
  input  logic        cpuU,
  input  logic [15:0] cpuWR,
  output logic [15:0] cpuRD,
  output logic        cpu_ack,
  output logic [24:1] sd_cpuAddr,
  output logic [1:0]  sd_cpustate,
  output logic        sd_cpuL,
  output logic        sd_cpuU,
  output logic [15:0] sd_cpuWR,
  input  logic [15:0] sd_cpuRD,
  input  logic        sd_cpuena,
  output logic        wb_empty,
  output logic        wb_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_GAP
  } state_t;

  logic [41:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_n;
  logic [24:1]   r_sd_addr;
  logic [24:1]   w_sd_addr_n;
  logic [1:0]    r_sd_state;
  logic [1:0]    w_sd_state_n;
  logic          r_sd_l;
  logic          w_sd_l_n;
  logic          r_sd_u;
  logic          w_sd_u_n;
  logic [15:0]   r_sd_wr;
  logic [15:0]   w_sd_wr_n;
  logic [15:0]   r_cpu_rd;
  logic [15:0]   w_cpu_rd_n;
  logic          r_ack;
  logic          w_ack_n;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_rd_req;
  logic [41:0]   w_head;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  // r_ack blocks a second push of a request still held in the ack cycle
  assign w_push   = (cpustate == 2'b11) && !w_full && !r_ack;
  assign w_rd_req = (cpustate == 2'b00) || (cpustate == 2'b10);
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge sysclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cpuAddr, cpuL, cpuU, cpuWR};
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_sd_addr_n  = r_sd_addr;
    w_sd_state_n = r_sd_state;
    w_sd_l_n     = r_sd_l;
    w_sd_u_n     = r_sd_u;
    w_sd_wr_n    = r_sd_wr;
    w_cpu_rd_n   = r_cpu_rd;
    w_ack_n      = w_push;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_sd_addr_n  = w_head[41:18];
          w_sd_l_n     = w_head[17];
          w_sd_u_n     = w_head[16];
          w_sd_wr_n    = w_head[15:0];
          w_sd_state_n = 2'b11;
          w_state_n    = S_WR_REQ;
        end else if (w_rd_req) begin
          w_sd_addr_n  = cpuAddr;
          w_sd_l_n     = cpuL;
          w_sd_u_n     = cpuU;
          w_sd_state_n = cpustate;
          w_state_n    = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (sd_cpuena) begin
          w_pop        = 1'b1;
          w_sd_state_n = 2'b01;
          w_state_n    = S_GAP;
        end
      end
      S_RD_REQ: begin
        if (sd_cpuena) begin
          w_cpu_rd_n   = sd_cpuRD;
          w_ack_n      = 1'b1;
          w_sd_state_n = 2'b01;
          w_state_n    = S_GAP;
        end
      end
      S_GAP: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sd_addr  <= '0;
      r_sd_state <= 2'b01;
      r_sd_l     <= 1'b1;
      r_sd_u     <= 1'b1;
      r_sd_wr    <= '0;
      r_cpu_rd   <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_sd_addr  <= w_sd_addr_n;
      r_sd_state <= w_sd_state_n;
      r_sd_l     <= w_sd_l_n;
      r_sd_u     <= w_sd_u_n;
      r_sd_wr    <= w_sd_wr_n;
      r_cpu_rd   <= w_cpu_rd_n;
      r_ack      <= w_ack_n;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign cpuRD       = r_cpu_rd;
  assign cpu_ack     = r_ack;
  assign sd_cpuAddr  = r_sd_addr;
  assign sd_cpustate = r_sd_state;
  assign sd_cpuL     = r_sd_l;
  assign sd_cpuU     = r_sd_u;
  assign sd_cpuWR    = r_sd_wr;
  assign wb_empty    = w_empty;
  assign wb_full     = w_full;

endmodule

// File: tb/tb_cpu_write_buffer.sv
// tb_cpu_write_buffer: directed + random checks of the posted-write buffer
// against an SDRAM controller model and a program-order memory model.
module tb_cpu_write_buffer;
  typedef struct packed {
    logic [1:0]  st;
    logic [23:0] a;
    logic        l;
    logic        u;
    logic [15:0] d;
  } txn_t;

  logic        sysclk;
  logic        reset_n;
  logic [23:0] cpuAddr;
  logic [1:0]  cpustate;
  logic        cpuL;
  logic        cpuU;
  logic [15:0] cpuWR;
  logic [15:0] cpuRD;
  logic        cpu_ack;
  logic [23:0] sd_cpuAddr;
  logic [1:0]  sd_cpustate;
  logic        sd_cpuL;
  logic        sd_cpuU;
  logic [15:0] sd_cpuWR;
  logic [15:0] sd_cpuRD;
  logic        sd_cpuena;
  logic        wb_empty;
  logic        wb_full;

  int checks;
  int failures;
  bit ctrl_on;
  int ctrl_lat;
  logic [15:0] smem [logic [23:0]];
  txn_t tlog [$];

  cpu_write_buffer #(.DEPTH(4)) dut (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .cpuAddr(cpuAddr),
    .cpustate(cpustate),
    .cpuL(cpuL),
    .cpuU(cpuU),
    .cpuWR(cpuWR),
    .cpuRD(cpuRD),
    .cpu_ack(cpu_ack),
    .sd_cpuAddr(sd_cpuAddr),
    .sd_cpustate(sd_cpustate),
    .sd_cpuL(sd_cpuL),
    .sd_cpuU(sd_cpuU),
    .sd_cpuWR(sd_cpuWR),
    .sd_cpuRD(sd_cpuRD),
    .sd_cpuena(sd_cpuena),
    .wb_empty(wb_empty),
    .wb_full(wb_full)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // SDRAM controller model: answers each request ctrl_lat cycles late
  initial begin : ctrl_model
    int busy;
    txn_t t;
    logic [15:0] w;
    busy = 0;
    sd_cpuena = 1'b0;
    sd_cpuRD = '0;
    forever begin
      @(negedge sysclk);
      sd_cpuena = 1'b0;
      if (ctrl_on && reset_n && sd_cpustate != 2'b01) begin
        if (busy < ctrl_lat) begin
          busy++;
        end else begin
          t = {sd_cpustate, sd_cpuAddr, sd_cpuL, sd_cpuU, sd_cpuWR};
          tlog.push_back(t);
          w = smem.exists(sd_cpuAddr) ? smem[sd_cpuAddr] : 16'h0;
          if (sd_cpustate == 2'b11) begin
            if (!sd_cpuL) w[7:0] = sd_cpuWR[7:0];
            if (!sd_cpuU) w[15:8] = sd_cpuWR[15:8];
            smem[sd_cpuAddr] = w;
          end else begin
            sd_cpuRD = w;
          end
          sd_cpuena = 1'b1;
          busy = 0;
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic cpu_write(input logic [23:0] a, input logic [15:0] d,
                           input logic l, input logic u,
                           output bit ok, output int n);
    cpuAddr = a;
    cpuWR = d;
    cpuL = l;
    cpuU = u;
    cpustate = 2'b11;
    ok = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge sysclk);
      #1;
      n++;
      if (cpu_ack) begin
        ok = 1;
        break;
      end
    end
    cpustate = 2'b01;
  endtask

  task automatic cpu_read(input logic [1:0] st, input logic [23:0] a,
                          output logic [15:0] d, output bit ok);
    cpuAddr = a;
    cpuL = 1'b0;
    cpuU = 1'b0;
    cpustate = st;
    ok = 0;
    d = 'x;
    for (int i = 0; i < 300; i++) begin
      @(posedge sysclk);
      #1;
      if (cpu_ack) begin
        ok = 1;
        d = cpuRD;
        break;
      end
    end
    cpustate = 2'b01;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge sysclk);
      #1;
      if (wb_empty && sd_cpustate == 2'b01) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpustate = 2'b01;
    cpuAddr = '0;
    cpuWR = '0;
    cpuL = 1'b1;
    cpuU = 1'b1;
    ctrl_on = 0;
    ctrl_lat = 0;
    #12;
    checks++;
    if ({sd_cpustate, sd_cpuL, sd_cpuU, sd_cpuAddr, sd_cpuWR, cpuRD,
         cpu_ack, wb_empty, wb_full} !==
        {2'b01, 1'b1, 1'b1, 24'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_held: got %h/%b%b %h %h %h %b%b%b", sd_cpustate,
               sd_cpuL, sd_cpuU, sd_cpuAddr, sd_cpuWR, cpuRD, cpu_ack,
               wb_empty, wb_full);
    end
    @(negedge sysclk);
    reset_n = 1'b1;
    @(posedge sysclk);
    #1;
    checks++;
    if ({sd_cpustate, sd_cpuL, sd_cpuU, sd_cpuAddr, sd_cpuWR, cpuRD,
         cpu_ack, wb_empty, wb_full} !==
        {2'b01, 1'b1, 1'b1, 24'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_release: got %h %h %h %b%b%b", sd_cpustate,
               sd_cpuAddr, cpuRD, cpu_ack, wb_empty, wb_full);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    int n;
    bit got;
    ctrl_on = 0;
    tlog.delete();
    cpu_write(24'h000100, 16'hA5A5, 1'b0, 1'b0, ok, n);
    checks++;
    if (!ok || n != 1) begin
      failures++;
      $display("FAIL single_ack_lat: ok=%0b cycles=%0d expected 1", ok, n);
    end
    @(posedge sysclk);
    #1;
    checks++;
    if ({sd_cpustate, sd_cpuAddr, sd_cpuL, sd_cpuU, sd_cpuWR, wb_empty} !==
        {2'b11, 24'h000100, 1'b0, 1'b0, 16'hA5A5, 1'b0}) begin
      failures++;
      $display("FAIL single_drain_start: got %h %h %b%b %h e=%b",
               sd_cpustate, sd_cpuAddr, sd_cpuL, sd_cpuU, sd_cpuWR, wb_empty);
    end
    ctrl_lat = 1;
    ctrl_on = 1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge sysclk);
      #1;
      if (tlog.size() >= 1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || sd_cpustate !== 2'b01 || wb_empty !== 1'b1) begin
      failures++;
      $display("FAIL single_gap: got=%0b st=%b empty=%b want st=01 empty=1",
               got, sd_cpustate, wb_empty);
    end
    checks++;
    if (tlog.size() != 1 ||
        tlog[0] !== {2'b11, 24'h000100, 1'b0, 1'b0, 16'hA5A5}) begin
      failures++;
      $display("FAIL single_txn: n=%0d first=%h", tlog.size(),
               tlog.size() > 0 ? tlog[0] : '0);
    end
    @(posedge sysclk);
    #1;
    checks++;
    if (sd_cpustate !== 2'b01) begin
      failures++;
      $display("FAIL single_idle: sd_cpustate=%b want 01", sd_cpustate);
    end
  endtask

  task automatic test_burst_full();
    bit ok;
    bit all_ok;
    bit stall_bad;
    bit got;
    int n;
    int lsz;
    ctrl_on = 0;
    tlog.delete();
    all_ok = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_write(24'h000400 + 24'(i), 16'h1111 * 16'(i + 1), 1'b0, 1'b0,
                ok, n);
      if (!ok) all_ok = 0;
    end
    checks++;
    if (!all_ok || wb_full !== 1'b1) begin
      failures++;
      $display("FAIL burst_fill: acks_ok=%0b wb_full=%b want 1", all_ok,
               wb_full);
    end
    cpuAddr = 24'h000404;
    cpuWR = 16'h5555;
    cpuL = 1'b0;
    cpuU = 1'b0;
    cpustate = 2'b11;
    stall_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sysclk);
      #1;
      if (cpu_ack) stall_bad = 1;
    end
    checks++;
    if (stall_bad) begin
      failures++;
      $display("FAIL burst_stall: cpu_ack=1 while full, want 0");
    end
    ctrl_lat = 0;
    ctrl_on = 1;
    got = 0;
    lsz = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sysclk);
      #1;
      if (cpu_ack) begin
        got = 1;
        lsz = tlog.size();
        break;
      end
    end
    cpustate = 2'b01;
    checks++;
    if (!got || lsz != 1) begin
      failures++;
      $display("FAIL burst_5th_ack: acked=%0b drained=%0d want 1 1", got,
               lsz);
    end
    wait_drain(ok);
    checks++;
    if (!ok || tlog.size() != 5) begin
      failures++;
      $display("FAIL burst_drain: ok=%0b n=%0d want 5", ok, tlog.size());
    end
    for (int i = 0; i < tlog.size() && i < 5; i++) begin
      checks++;
      if (tlog[i] !== {2'b11, 24'h000400 + 24'(i), 1'b0, 1'b0,
                       16'h1111 * 16'(i + 1)}) begin
        failures++;
        $display("FAIL burst_order[%0d]: got %h", i, tlog[i]);
      end
    end
  endtask

  task automatic test_read_after_write();
    bit ok;
    int n;
    logic [15:0] d;
    ctrl_on = 1;
    ctrl_lat = 2;
    tlog.delete();
    cpu_write(24'h000200, 16'hBEEF, 1'b0, 1'b0, ok, n);
    cpu_read(2'b10, 24'h000200, d, ok);
    checks++;
    if (!ok || d !== 16'hBEEF) begin
      failures++;
      $display("FAIL raw_data: ok=%0b cpuRD=%h want beef", ok, d);
    end
    checks++;
    if (tlog.size() != 2 || tlog[0].st !== 2'b11 || tlog[1].st !== 2'b10 ||
        tlog[1].a !== 24'h000200) begin
      failures++;
      $display("FAIL raw_order: n=%0d want write then read", tlog.size());
    end
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    bit all_ok;
    int n;
    txn_t exq [$];
    ctrl_on = 0;
    tlog.delete();
    cpu_write(24'h000500, 16'h0001, 1'b0, 1'b0, ok, n);
    exq.push_back({2'b11, 24'h000500, 1'b0, 1'b0, 16'h0001});
    cpu_write(24'h000501, 16'h0002, 1'b0, 1'b0, ok, n);
    exq.push_back({2'b11, 24'h000501, 1'b0, 1'b0, 16'h0002});
    @(posedge sysclk);
    #1;
    ctrl_lat = 0;
    ctrl_on = 1;
    cpu_write(24'h000502, 16'h0003, 1'b0, 1'b0, ok, n);
    ctrl_on = 0;
    exq.push_back({2'b11, 24'h000502, 1'b0, 1'b0, 16'h0003});
    checks++;
    if (!ok || n != 1 || tlog.size() != 1) begin
      failures++;
      $display("FAIL simul_same_cycle: ok=%0b lat=%0d popped=%0d want 1 1",
               ok, n, tlog.size());
    end
    cpu_write(24'h000503, 16'h0004, 1'b0, 1'b0, ok, n);
    exq.push_back({2'b11, 24'h000503, 1'b0, 1'b0, 16'h0004});
    checks++;
    if (wb_full !== 1'b0) begin
      failures++;
      $display("FAIL simul_count3: wb_full=%b want 0", wb_full);
    end
    cpu_write(24'h000504, 16'h0005, 1'b0, 1'b0, ok, n);
    exq.push_back({2'b11, 24'h000504, 1'b0, 1'b0, 16'h0005});
    checks++;
    if (wb_full !== 1'b1) begin
      failures++;
      $display("FAIL simul_count4: wb_full=%b want 1", wb_full);
    end
    ctrl_on = 1;
    all_ok = 1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      logic [23:0] a;
      ctrl_lat = int'($urandom_range(0, 2));
      d = 16'($urandom);
      a = 24'h000510 + 24'(i);
      cpu_write(a, d, 1'b0, 1'b0, ok, n);
      if (!ok) all_ok = 0;
      exq.push_back({2'b11, a, 1'b0, 1'b0, d});
    end
    wait_drain(ok);
    checks++;
    if (!all_ok || !ok || tlog.size() != exq.size()) begin
      failures++;
      $display("FAIL simul_wrap: acks=%0b drained=%0b n=%0d want %0d",
               all_ok, ok, tlog.size(), exq.size());
    end
    for (int i = 0; i < tlog.size() && i < exq.size(); i++) begin
      checks++;
      if (tlog[i] !== exq[i]) begin
        failures++;
        $display("FAIL simul_order[%0d]: got %h want %h", i, tlog[i],
                 exq[i]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    bit ok;
    int n;
    logic [15:0] d;
    ctrl_on = 1;
    ctrl_lat = 1;
    tlog.delete();
    cpu_write(24'h000300, 16'h3456, 1'b0, 1'b0, ok, n);
    cpu_write(24'h000300, 16'h12FF, 1'b0, 1'b1, ok, n);
    cpu_write(24'h000300, 16'hABCD, 1'b1, 1'b1, ok, n);
    cpu_read(2'b10, 24'h000300, d, ok);
    checks++;
    if (tlog.size() != 4 || tlog[1].l !== 1'b0 || tlog[1].u !== 1'b1 ||
        tlog[1].d !== 16'h12FF) begin
      failures++;
      $display("FAIL lanes_fwd: n=%0d entry=%h", tlog.size(),
               tlog.size() > 1 ? tlog[1] : '0);
    end
    checks++;
    if (tlog.size() != 4 || tlog[2].l !== 1'b1 || tlog[2].u !== 1'b1) begin
      failures++;
      $display("FAIL lanes_none_fwd: n=%0d want L=U=1 write forwarded",
               tlog.size());
    end
    checks++;
    if (!ok || d !== 16'h34FF) begin
      failures++;
      $display("FAIL lanes_read: ok=%0b cpuRD=%h want 34ff", ok, d);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    bit bad;
    int n;
    ctrl_on = 0;
    tlog.delete();
    for (int i = 0; i < 3; i++) begin
      cpu_write(24'h000700 + 24'(i), 16'h7000 + 16'(i), 1'b0, 1'b0, ok, n);
    end
    @(posedge sysclk);
    #1;
    checks++;
    if (sd_cpustate !== 2'b11 || wb_empty !== 1'b0) begin
      failures++;
      $display("FAIL rst_pre: sd_cpustate=%b empty=%b want 11 0",
               sd_cpustate, wb_empty);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sd_cpustate, sd_cpuL, sd_cpuU, sd_cpuAddr, sd_cpuWR, cpuRD,
         cpu_ack, wb_empty, wb_full} !==
        {2'b01, 1'b1, 1'b1, 24'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_async: got %h/%b%b %h %h %h %b%b%b", sd_cpustate,
               sd_cpuL, sd_cpuU, sd_cpuAddr, sd_cpuWR, cpuRD, cpu_ack,
               wb_empty, wb_full);
    end
    @(negedge sysclk);
    reset_n = 1'b1;
    ctrl_on = 1;
    ctrl_lat = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sysclk);
      #1;
      if (sd_cpustate !== 2'b01 || wb_empty !== 1'b1) bad = 1;
    end
    checks++;
    if (bad || tlog.size() != 0) begin
      failures++;
      $display("FAIL rst_quiet: request after reset, txns=%0d want 0",
               tlog.size());
    end
    ctrl_on = 0;
    cpu_write(24'h000600, 16'h7777, 1'b0, 1'b0, ok, n);
    @(posedge sysclk);
    #1;
    checks++;
    if (!ok || sd_cpustate !== 2'b11 || sd_cpuAddr !== 24'h000600) begin
      failures++;
      $display("FAIL rst_new_write: ok=%0b st=%b addr=%h want 11 000600",
               ok, sd_cpustate, sd_cpuAddr);
    end
    ctrl_on = 1;
    wait_drain(ok);
  endtask

  task automatic test_random();
    bit ok;
    bit drained;
    int n;
    logic [15:0] rmem [logic [23:0]];
    txn_t exq [$];
    txn_t wq [$];
    tlog.delete();
    ctrl_on = 1;
    for (int k = 0; k < 60; k++) begin
      int op;
      logic [23:0] a;
      logic [15:0] d;
      logic [15:0] e;
      logic l;
      logic u;
      ctrl_lat = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 9));
      a = 24'h001000 + 24'($urandom_range(0, 7));
      if (op < 6) begin
        d = 16'($urandom);
        l = 1'($urandom_range(0, 1));
        u = 1'($urandom_range(0, 1));
        cpu_write(a, d, l, u, ok, n);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL rand_wr_ack[%0d]: no cpu_ack", k);
        end else begin
          e = rmem.exists(a) ? rmem[a] : 16'h0;
          if (!l) e[7:0] = d[7:0];
          if (!u) e[15:8] = d[15:8];
          rmem[a] = e;
          exq.push_back({2'b11, a, l, u, d});
        end
      end else begin
        cpu_read(op < 9 ? 2'b10 : 2'b00, a, d, ok);
        e = rmem.exists(a) ? rmem[a] : 16'h0;
        checks++;
        if (!ok || d !== e) begin
          failures++;
          $display("FAIL rand_rd[%0d]: addr=%h ok=%0b got %h want %h", k, a,
                   ok, d, e);
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge sysclk);
        #1;
      end
    end
    wait_drain(drained);
    foreach (tlog[i]) begin
      if (tlog[i].st == 2'b11) wq.push_back(tlog[i]);
    end
    checks++;
    if (!drained || wq.size() != exq.size()) begin
      failures++;
      $display("FAIL rand_wr_count: drained=%0b got %0d want %0d", drained,
               wq.size(), exq.size());
    end
    for (int i = 0; i < wq.size() && i < exq.size(); i++) begin
      checks++;
      if (wq[i] !== exq[i]) begin
        failures++;
        $display("FAIL rand_wr_order[%0d]: got %h want %h", i, wq[i],
                 exq[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_write();
    test_burst_full();
    test_read_after_write();
    test_simul_push_pop();
    test_byte_lanes();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
